neuron_seq_ctrl: RTL



---
 rtl/nn_pkg.sv | 19 +
 rtl/fx_mac.sv | 52 +++++
 rtl/neuron_seq_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron sequencing datapath.
// Q(32-FRAC_W).FRAC_W fixed point, signed accumulator of ACC_W bits.
package nn_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;
    localparam int ACC_W  = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FINAL = 2'd3
    } state_t;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 32'sh8000_0000;

endpackage

// File: rtl/fx_mac.sv
// Fixed-point multiply-accumulate: registered shifted product with valid flag,
// followed by an accumulator with synchronous clear.
module fx_mac #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] shifted_s;
    logic signed [ACC_W-1:0]  prod_r;
    logic                     valid_r;
    logic signed [ACC_W-1:0]  acc_r;

    // Full-precision signed product, arithmetic shift rounds toward -inf
    always_comb begin
        prod_s    = PROD_W'(a) * PROD_W'(b);
        shifted_s = prod_s >>> FRAC_W;
    end

    // Product stage and accumulator; clear drops any in-flight product too
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_r  <= {ACC_W{1'b0}};
            valid_r <= 1'b0;
            acc_r   <= {ACC_W{1'b0}};
        end else if (clear) begin
            prod_r  <= {ACC_W{1'b0}};
            valid_r <= 1'b0;
            acc_r   <= {ACC_W{1'b0}};
        end else begin
            prod_r  <= ACC_W'(shifted_s);
            valid_r <= en;
            if (valid_r) begin
                acc_r <= acc_r + prod_r;
            end
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/neuron_seq_ctrl.sv
// Sequences one neuron's dot product, adds bias, saturates and pulses done.
// Optional macro NEURON_RELU_EN clamps negative results to zero (ReLU).
module neuron_seq_ctrl
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS = 784,
    parameter int FRAC_W     = nn_pkg::FRAC_W,
    parameter int ACC_W      = nn_pkg::ACC_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bias_in,
    output logic [31:0] rd_addr,
    input  logic [31:0] w_data,
    input  logic [31:0] x_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int          SUM_W     = ACC_W + 1;
    localparam logic [31:0] LAST_ADDR = 32'(NUM_INPUTS - 1);

    state_t                    state_r;
    state_t                    state_s;
    logic [31:0]               rd_addr_r;
    logic                      busy_r;
    logic                      done_r;
    logic signed [DATA_W-1:0]  result_r;
    logic signed [DATA_W-1:0]  bias_r;
    logic                      accept_s;
    logic                      mac_en_s;
    logic signed [ACC_W-1:0]   acc_s;
    logic signed [SUM_W-1:0]   sum_s;
    logic signed [DATA_W-1:0]  sat_s;
    logic signed [DATA_W-1:0]  res_s;

    fx_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept_s),
        .en    (mac_en_s),
        .a     ($signed(w_data)),
        .b     ($signed(x_data)),
        .acc   (acc_s)
    );

    // Next-state logic and datapath controls
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        mac_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                mac_en_s = 1'b1;
                if (rd_addr_r == LAST_ADDR) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN:   state_s = FINAL;
            FINAL:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Bias add with saturation to the 32-bit signed range, optional ReLU
    always_comb begin
        sum_s = SUM_W'(acc_s) + SUM_W'(bias_r);
        if (sum_s > SUM_W'(SAT_MAX)) begin
            sat_s = SAT_MAX;
        end else if (sum_s < SUM_W'(SAT_MIN)) begin
            sat_s = SAT_MIN;
        end else begin
            sat_s = sum_s[DATA_W-1:0];
        end
`ifdef NEURON_RELU_EN
        if (sat_s[DATA_W-1]) begin
            res_s = {DATA_W{1'b0}};
        end else begin
            res_s = sat_s;
        end
`else
        res_s = sat_s;
`endif
    end

    // State, address counter and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            rd_addr_r <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= {DATA_W{1'b0}};
            bias_r    <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    rd_addr_r <= 32'd0;
                    if (accept_s) begin
                        bias_r <= $signed(bias_in);
                        busy_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (rd_addr_r == LAST_ADDR) begin
                        rd_addr_r <= 32'd0;
                    end else begin
                        rd_addr_r <= rd_addr_r + 32'd1;
                    end
                end
                DRAIN: rd_addr_r <= 32'd0;
                FINAL: begin
                    result_r <= res_s;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                end
                default: rd_addr_r <= 32'd0;
            endcase
        end
    end

    assign rd_addr = rd_addr_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;

endmodule
